// File: rtl/pc_sequencer_if.sv
// Instruction-memory fetch handshake between the PC sequencer (master) and imem (slave).
interface pc_sequencer_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;

    modport master (output imem_req, output imem_addr, input imem_ack);
    modport slave  (input imem_req, input imem_addr, output imem_ack);
endinterface

// File: rtl/pc_sequencer.sv
// Fetch-side PC sequencer: BOOT -> FETCH <-> UPDATE, HALT until reset.
// Optional fetch timeout watchdog enabled by defining IMEM_TIMEOUT_EN.
module pc_sequencer #(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter int          TIMEOUT   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pc_sequencer_if.master        imem,
    input  logic                  i_stall,
    input  logic                  i_br_taken,
    input  logic [15:0]           i_br_offset,
    input  logic                  i_jump,
    input  logic [25:0]           i_jump_target,
    input  logic                  i_halt,
    output logic [31:0]           o_pc_out,
    output logic [31:0]           o_pc_plus4,
    output logic                  o_pc_update,
    output logic                  o_halted,
    output logic                  o_fault
);

    typedef enum logic [1:0] {S_BOOT, S_FETCH, S_UPDATE, S_HALT} state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_pc;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_pc_next;
    logic        w_timeout;

`ifdef IMEM_TIMEOUT_EN
    localparam int              TW   = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]   TLIM = TW'(TIMEOUT - 1);

    logic [TW-1:0] r_tcnt;
    logic          r_fault;

    // r_tcnt counts ack-less FETCH cycles already elapsed; an ack in the last one still wins
    assign w_timeout = (r_state == S_FETCH) && !imem.imem_ack && (r_tcnt == TLIM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tcnt  <= '0;
            r_fault <= 1'b0;
        end else begin
            if (r_state != S_FETCH)
                r_tcnt <= '0;
            else if (!imem.imem_ack)
                r_tcnt <= r_tcnt + 1'b1;
            if (w_timeout)
                r_fault <= 1'b1;
        end
    end

    assign o_fault = r_fault;
`else
    assign w_timeout = 1'b0;
    // TIMEOUT is meaningless without the watchdog; the expression is constant 0
    assign o_fault   = (TIMEOUT < 0);
`endif

    assign w_pc_plus4     = r_pc + 32'd4;
    assign o_pc_plus4     = w_pc_plus4;
    assign o_pc_out       = r_pc;
    assign imem.imem_addr = r_pc;

    always_comb begin
        w_pc_next = w_pc_plus4;
        if (i_jump)
            w_pc_next = {w_pc_plus4[31:28], i_jump_target, 2'b00};
        else if (i_br_taken)
            w_pc_next = w_pc_plus4 + {{14{i_br_offset[15]}}, i_br_offset, 2'b00};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_BOOT;
            r_pc    <= RESET_VEC;
        end else begin
            r_state <= w_state_next;
            if (o_pc_update)
                r_pc <= w_pc_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_BOOT:   w_state_next = S_FETCH;
            S_FETCH: begin
                // halt outranks ack; a same-cycle timeout also ends in HALT
                if (i_halt || (!imem.imem_ack && w_timeout))
                    w_state_next = S_HALT;
                else if (imem.imem_ack)
                    w_state_next = S_UPDATE;
            end
            S_UPDATE: begin
                if (i_halt)
                    w_state_next = S_HALT;
                else if (!i_stall)
                    w_state_next = S_FETCH;
            end
            S_HALT:   w_state_next = S_HALT;
            default:  w_state_next = S_BOOT;
        endcase
    end

    always_comb begin
        imem.imem_req = (r_state == S_FETCH);
        o_halted      = (r_state == S_HALT);
        o_pc_update   = (r_state == S_UPDATE) && !i_stall && !i_halt;
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer; timeout checks follow IMEM_TIMEOUT_EN.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rst2_n = 1'b0;
    logic        stall = 1'b0;
    logic        br = 1'b0;
    logic [15:0] off = '0;
    logic        jump = 1'b0;
    logic [25:0] tgt = '0;
    logic        halt = 1'b0;

    logic [31:0] pc1, p41, pc2, p42;
    logic        upd1, halted1, fault1, upd2, halted2, fault2;

    int n_cmp = 0;
    int n_bad = 0;

    pc_sequencer_if if1();
    pc_sequencer_if if2();

    pc_sequencer #(.RESET_VEC(32'h0000_0000), .TIMEOUT(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .imem(if1),
        .i_stall(stall), .i_br_taken(br), .i_br_offset(off),
        .i_jump(jump), .i_jump_target(tgt), .i_halt(halt),
        .o_pc_out(pc1), .o_pc_plus4(p41), .o_pc_update(upd1),
        .o_halted(halted1), .o_fault(fault1)
    );

    pc_sequencer #(.RESET_VEC(32'h1000_0010), .TIMEOUT(4)) u_dut2 (
        .clk(clk), .rst_n(rst2_n), .imem(if2),
        .i_stall(stall), .i_br_taken(br), .i_br_offset(off),
        .i_jump(jump), .i_jump_target(tgt), .i_halt(halt),
        .o_pc_out(pc2), .o_pc_plus4(p42), .o_pc_update(upd2),
        .o_halted(halted2), .o_fault(fault2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset1();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    // one full instruction on dut1: FETCH at a with immediate ack, UPDATE with given controls
    task automatic instr(input logic [31:0] a, input logic j, input logic b,
                         input logic [25:0] t, input logic [15:0] o, input logic [31:0] nxt);
        chk("fetch_req", {31'd0, if1.imem_req}, 32'd1);
        chk("fetch_addr", if1.imem_addr, a);
        if1.imem_ack = 1'b1;
        step();
        if1.imem_ack = 1'b0;
        jump = j; br = b; tgt = t; off = o;
        #1;
        chk("upd_req", {31'd0, if1.imem_req}, 32'd0);
        chk("upd_pulse", {31'd0, upd1}, 32'd1);
        chk("upd_pc_hold", pc1, a);
        chk("pc_plus4", p41, a + 32'd4);
        step();
        jump = 1'b0; br = 1'b0;
        chk("next_pc", pc1, nxt);
        chk("pulse_end", {31'd0, upd1}, 32'd0);
        $display("instr pc=%h j=%0d b=%0d tgt=%h off=%h -> pc=%h", a, j, b, t, o, pc1);
    endtask

    initial begin
        if1.imem_ack = 1'b0;
        if2.imem_ack = 1'b0;
        #12;
        chk("rst_pc", pc1, 32'h0);
        chk("rst_req", {31'd0, if1.imem_req}, 32'd0);
        chk("rst_upd", {31'd0, upd1}, 32'd0);
        chk("rst_halted", {31'd0, halted1}, 32'd0);
        chk("rst_fault", {31'd0, fault1}, 32'd0);
        chk("rst_pc2", pc2, 32'h1000_0010);
        $display("reset state checked");

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("boot_req", {31'd0, if1.imem_req}, 32'd0);
        step();

        for (int i = 0; i < 4; i++)
            instr(32'(i * 4), 1'b0, 1'b0, 26'h0, 16'h0, 32'(i * 4 + 4));

        instr(32'h10,  1'b1, 1'b0, 26'h40, 16'h0,    32'h100);
        instr(32'h100, 1'b0, 1'b1, 26'h0,  16'd16,   32'h144);
        instr(32'h144, 1'b1, 1'b0, 26'h40, 16'h0,    32'h100);
        instr(32'h100, 1'b0, 1'b1, 26'h0,  16'hFFFE, 32'hFC);
        instr(32'hFC,  1'b1, 1'b1, 26'h80, 16'h10,   32'h200);
        instr(32'h200, 1'b0, 1'b1, 26'h0,  16'hFF7E, 32'hFFFF_FFFC);
        instr(32'hFFFF_FFFC, 1'b0, 1'b0, 26'h0, 16'h0, 32'h0);

        // ack withheld for three FETCH cycles
        for (int i = 0; i < 3; i++) begin
            step();
            chk("wait_req", {31'd0, if1.imem_req}, 32'd1);
            chk("wait_pc", pc1, 32'h0);
            $display("ack withheld cycle %0d pc=%h", i, pc1);
        end
        if1.imem_ack = 1'b1;
        step();
        if1.imem_ack = 1'b0;
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("stall_upd", {31'd0, upd1}, 32'd0);
            chk("stall_pc", pc1, 32'h0);
            $display("stall cycle %0d pc=%h", i, pc1);
            step();
        end
        stall = 1'b0;
        #1;
        chk("unstall_upd", {31'd0, upd1}, 32'd1);
        step();
        chk("unstall_pc", pc1, 32'h4);

        // asynchronous reset mid-FETCH
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_pc", pc1, 32'h0);
        chk("async_rst_req", {31'd0, if1.imem_req}, 32'd0);
        $display("async reset mid-fetch pc=%h", pc1);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("boot2_req", {31'd0, if1.imem_req}, 32'd0);
        halt = 1'b1;
        step();
        halt = 1'b0;
        chk("boot_halt_ignored", {31'd0, halted1}, 32'd0);
        chk("fetch_after_boot", {31'd0, if1.imem_req}, 32'd1);

        // halt together with ack
        if1.imem_ack = 1'b1;
        halt = 1'b1;
        step();
        if1.imem_ack = 1'b0;
        halt = 1'b0;
        chk("halt_ack_halted", {31'd0, halted1}, 32'd1);
        chk("halt_ack_req", {31'd0, if1.imem_req}, 32'd0);
        chk("halt_ack_pc", pc1, 32'h0);
        if1.imem_ack = 1'b1;
        step();
        step();
        if1.imem_ack = 1'b0;
        chk("halt_sticky", {31'd0, halted1}, 32'd1);
        chk("halt_pc_frozen", pc1, 32'h0);
        $display("halt with ack: halted=%0d pc=%h", halted1, pc1);

        // halt in UPDATE overrides jump
        reset1();
        if1.imem_ack = 1'b1;
        step();
        if1.imem_ack = 1'b0;
        halt = 1'b1; jump = 1'b1; tgt = 26'h40;
        #1;
        chk("halt_upd_pulse", {31'd0, upd1}, 32'd0);
        step();
        halt = 1'b0; jump = 1'b0;
        chk("halt_upd_halted", {31'd0, halted1}, 32'd1);
        chk("halt_upd_pc", pc1, 32'h0);
        $display("halt in update: halted=%0d pc=%h", halted1, pc1);

        // no ack for four FETCH cycles
        reset1();
        step(); step(); step();
        chk("to_pre_fault", {31'd0, fault1}, 32'd0);
        chk("to_pre_halted", {31'd0, halted1}, 32'd0);
        step();
`ifdef IMEM_TIMEOUT_EN
        chk("to_fault", {31'd0, fault1}, 32'd1);
        chk("to_halted", {31'd0, halted1}, 32'd1);
        chk("to_req", {31'd0, if1.imem_req}, 32'd0);
`else
        chk("to_fault", {31'd0, fault1}, 32'd0);
        chk("to_halted", {31'd0, halted1}, 32'd0);
        chk("to_req", {31'd0, if1.imem_req}, 32'd1);
`endif
        chk("to_pc", pc1, 32'h0);
        $display("four ack-less fetch cycles: fault=%0d halted=%0d", fault1, halted1);

        // ack in the fourth cycle is honoured
        reset1();
        step(); step(); step();
        if1.imem_ack = 1'b1;
        step();
        if1.imem_ack = 1'b0;
        chk("late_ack_fault", {31'd0, fault1}, 32'd0);
        chk("late_ack_halted", {31'd0, halted1}, 32'd0);
        chk("late_ack_upd", {31'd0, upd1}, 32'd1);
        step();
        chk("late_ack_pc", pc1, 32'h4);
        $display("ack in fourth cycle: fault=%0d pc=%h", fault1, pc1);

        // jump keeps the upper nibble of pc_plus4
        @(negedge clk);
        rst2_n = 1'b1;
        step();
        chk("j2_addr", if2.imem_addr, 32'h1000_0010);
        if2.imem_ack = 1'b1;
        step();
        if2.imem_ack = 1'b0;
        jump = 1'b1; tgt = 26'h40;
        #1;
        chk("j2_pulse", {31'd0, upd2}, 32'd1);
        step();
        jump = 1'b0;
        chk("j2_pc", pc2, 32'h1000_0100);
        $display("jump from 10000010 -> pc=%h", pc2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Fetch-side controller that owns and sequences the 32-bit program counter of the MIPS core.
- Issues instruction-memory fetch requests with a req/ack handshake.
- After each fetch, selects the next PC: sequential, branch (16-bit signed word offset) or jump (26-bit target).
- Honours pipeline stall and halt requests.
- Sits between the instruction memory and the decode stage and replaces ad-hoc PC update logic.

Parameters:
RESET_VEC, 32'h0000_0000, PC value loaded on reset.
TIMEOUT, 16, maximum cycles a fetch may wait for imem_ack; used only with IMEM_TIMEOUT_EN.

Ports:
clk  input  1  system clock, all state on rising edge.
rst_n  input  1  asynchronous, active-low reset.
imem_req  output  1  fetch request, held high until acknowledged.
imem_addr  output  32  fetch address; always equals pc_out.
imem_ack  input  1  instruction memory has returned the word for imem_addr this cycle.
stall  input  1  hold PC in UPDATE state.
br_taken  input  1  branch resolved taken, sampled in UPDATE.
br_offset  input  16  signed word offset (instruction immediate).
jump  input  1  unconditional jump, sampled in UPDATE.
jump_target  input  26  jump instruction index.
halt  input  1  request to stop fetching.
pc_out  output  32  current PC.
pc_plus4  output  32  pc_out + 4, mod 2^32, combinational.
pc_update  output  1  one-cycle pulse when PC is written with a new value.
halted  output  1  high in HALT state.
fault  output  1  fetch timeout flag; constant 0 without IMEM_TIMEOUT_EN.

Behaviour:
- Reset (rst_n low, asynchronous):
  - pc_out=RESET_VEC, state=BOOT.
  - imem_req=0, pc_update=0, halted=0, fault=0.
  - Asserting reset in any state, including mid-fetch, aborts immediately; no partial PC update.
- States: BOOT, FETCH, UPDATE, HALT.
- BOOT: one cycle after reset release, then FETCH. imem_req=0.
- FETCH:
  - imem_req=1, imem_addr=pc_out.
  - imem_ack=1 -> UPDATE next cycle. Otherwise stay; PC unchanged.
- UPDATE:
  - imem_req=0.
  - stall=1: stay in UPDATE, PC held, pc_update=0.
  - stall=0: write PC with priority jump > br_taken > sequential, assert pc_update for that one cycle, go to FETCH.
  - jump: pc <= {pc_plus4[31:28], jump_target, 2'b00}.
  - br_taken: pc <= pc_plus4 + ({{14{br_offset[15]}}, br_offset, 2'b00}), mod 2^32.
  - else: pc <= pc_plus4.
  - Both jump and br_taken high: jump wins.
- Arithmetic: all 32-bit, wrap silently. PC 32'hFFFF_FFFC sequential -> 32'h0000_0000.
- HALT:
  - Entered from FETCH or UPDATE when halt=1 on a clock edge.
  - halt takes priority over ack, stall, jump and branch in that cycle; no PC write.
  - halted=1, imem_req=0, PC frozen.
  - Exit only by reset.
  - halt in BOOT is ignored; it is re-sampled in FETCH.
- Latency: minimum two cycles per instruction (FETCH with immediate ack, then UPDATE).

Optional Feature:
IMEM_TIMEOUT_EN
- Defined:
  - A counter clears on FETCH entry and increments each FETCH cycle without ack.
  - On reaching TIMEOUT: fault=1 (sticky until reset), state -> HALT, halted=1, PC unchanged.
  - An ack arriving in the same cycle the count reaches TIMEOUT is honoured; no fault is raised.
- Undefined: no counter is built, fault tied 0, FETCH waits indefinitely.

Test Plan:
- Sequential run: RESET_VEC=0, release rst_n, ack every request -> imem_addr 0x0, 0x4, 0x8, 0xC on successive FETCH states; pc_update pulses once per instruction.
- Branch offsets:
  - Positive: pc=0x100, br_taken=1, br_offset=16'd16 -> pc=0x144.
  - Negative: pc=0x100, br_offset=16'hFFFE -> pc=0xFC.
  - Priority: jump=1 with br_taken=1 -> jump result.
- Jump: pc=0x1000_0010, jump=1, jump_target=26'h40 -> pc=0x1000_0100. Wrap: sequential from 0xFFFF_FFFC -> 0x0.
- Stall/ack delay:
  - ack withheld 3 cycles -> imem_req held, PC stable.
  - stall high 4 cycles in UPDATE -> no pc_update, PC stable; stall release -> PC+4 one cycle later.
- Halt and reset:
  - halt=1 in same cycle as imem_ack -> HALT, PC unchanged, halted=1.
  - rst_n pulsed low mid-FETCH -> pc_out=RESET_VEC immediately, state BOOT.
- Timeout (IMEM_TIMEOUT_EN, TIMEOUT=4): no ack -> fault=1 and halted=1 after 4 FETCH cycles. Repeat with ack in cycle 4 -> no fault, normal UPDATE.
